sevseg_scan_decoder: RTL and testbench
======================================

# sevseg_scan_decoder

Receive-side companion to the hex-to-seven-segment encoder: it snoops a multiplexed, active-low 4-digit seven-segment display bus and reconstructs the displayed 16-bit hex value. Used on the lab board's test harness to check the display driver end-to-end. It samples the anode/segment lines, waits for a stable pattern per digit, decodes each pattern back to a nibble and emits a complete frame once all four digits have been seen.

## Interface

- STABLE_CYCLES, default 4, consecutive synchronized cycles a pattern must hold before capture; legal range 2..255.
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- seg_n  input  7  segment lines, active-low; bit0 = seg a … bit6 = seg g.
- an_n  input  4  digit enables, active-low; an_n[3] = most significant digit.
- frame_data  output  16  last complete value; digit 3 in [15:12] … digit 0 in [3:0].
- frame_valid  output  1  one-cycle pulse when frame_data updates.
- digit_err  output  1  one-cycle pulse on capture of an undecodable pattern.
- err_digit  output  2  index of the digit that caused the last digit_err.
- err_count  output  8  saturating error count; present only with SEVSEG_ERR_CNT_EN.

## Operation

- Input path: seg_n and an_n pass through a 2-flop synchronizer as an 11-bit vector `s`.
- FSM, three states:
  - CHANGING: `s` differs from held copy `p`. Load `p <= s`, `cnt <= 1`.
  - COUNTING: `s == p`, so `cnt` increments. Reaching STABLE_CYCLES fires a capture and moves to HELD. Any change in `s` returns to CHANGING.
  - HELD: no further capture until `s` changes; then go to CHANGING.
- Capture with an_n one-hot-low:
  - Index `i` is the position of the 0 bit.
  - Decode table, active-high on-set (bit6..0 = g..a): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71. seg_n is the bitwise inverse.
  - Matching pattern: `shadow[i] <= nibble`, `seen[i] <= 1`.
  - Any other pattern (including all-off 7'h7F on seg_n): pulse digit_err, `err_digit <= i`, clear `seen` to 0; shadow is unchanged.
- Capture with an_n not one-hot (all high = blanking gap, or multiple low): ignored. No error and no state change besides the FSM.
- Frame completion: when a valid capture makes `seen == 4'hF`:
  - frame_data is loaded with the 4 shadow nibbles, including the one just captured.
  - frame_valid pulses.
  - `seen` clears.
- Re-capturing an already-seen digit overwrites its shadow nibble and does not complete the frame early.

## Timing

- Reset values: frame_data = 16'h0000, frame_valid = 0, digit_err = 0, err_digit = 0, err_count = 0, seen = 0, shadow = 0. The synchronizer and `p` reset to all ones, `cnt` to 0, and the FSM to CHANGING.
- Reset asserted mid-operation abandons the partial frame immediately. After release, capture needs a full new stable window.
- Latency: a pin pattern first present before edge E0 is captured at edge E0 + STABLE_CYCLES + 1. frame_valid, digit_err and frame_data update at that capture edge and are registered outputs.
- A pattern held for fewer than STABLE_CYCLES synchronized cycles is never captured.
- frame_valid and digit_err are never high in the same cycle. Each is high for exactly one cycle per capture.
- A constant input yields exactly one capture, however long it is held.

## Configuration

- SEVSEG_ERR_CNT_EN defined:
  - Adds output err_count[7:0].
  - err_count increments on each digit_err pulse and saturates at 255.
  - It is cleared only by reset.
- SEVSEG_ERR_CNT_EN undefined: the port and counter are absent. All other behaviour is identical.

## Test plan

- Scan digits 3..0 showing 1, 2, A, F, each held 8 cycles with 2-cycle all-high gaps (STABLE_CYCLES=4) -> one frame_valid pulse with frame_data = 16'h12AF, and no digit_err.
- Digit 2 shows seg_n = 7'h7F (blank) while the others are valid -> digit_err pulse with err_digit = 2, no frame_valid. The next clean scan of 4'h5, 4'h6, 4'h7, 4'h8 gives frame_data = 16'h5678.
- Digit 0 toggles between two patterns every 3 cycles (STABLE_CYCLES=4) -> no capture for digit 0 and no frame_valid. After it settles on 4'hC, frame_data[3:0] = 4'hC.
- an_n = 4'b0011 (two digits low) held for 20 cycles -> no capture, no digit_err, and the `seen` state is unaffected.
- Reset asserted after 3 digits are captured, then 4 digits scanned as 9, 8, 7, 6 -> exactly one frame_valid with frame_data = 16'h9876.
- With SEVSEG_ERR_CNT_EN defined, 300 invalid captures -> err_count = 255 (saturated); after reset it reads 0.

Source files
------------

// File: rtl/sevseg_scan_decoder.sv
// Snoops a multiplexed active-low 4-digit seven-segment bus and rebuilds the 16-bit hex frame.
// Optional saturating error counter output err_count enabled by defining SEVSEG_ERR_CNT_EN.
module sevseg_scan_decoder #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  seg_n,
    input  logic [3:0]  an_n,
    output logic [15:0] frame_data,
    output logic        frame_valid,
    output logic        digit_err,
    output logic [1:0]  err_digit
`ifdef SEVSEG_ERR_CNT_EN
    ,
    output logic [7:0]  err_count
`endif
);

    localparam logic [1:0] CHANGING = 2'd0;
    localparam logic [1:0] COUNTING = 2'd1;
    localparam logic [1:0] HELD     = 2'd2;

    localparam logic [7:0] CAP_CNT = 8'(STABLE_CYCLES - 1);

    logic [10:0] syncA;
    logic [10:0] syncB;
    logic [10:0] heldPat;
    logic [10:0] heldPatNext;
    logic [7:0]  cnt;
    logic [7:0]  cntNext;
    logic [1:0]  state;
    logic [1:0]  stateNext;
    logic        capture;

    logic [1:0]  digitIdx;
    logic        anOneHot;
    logic        decValid;
    logic [3:0]  decNibble;
    logic        captureOk;
    logic        captureErr;

    logic [15:0] shadow;
    logic [15:0] shadowNext;
    logic [3:0]  seen;
    logic [3:0]  seenNext;

    function automatic logic [4:0] decodeSeg(input logic [6:0] segOn);
        case (segOn)
            7'h3F:   decodeSeg = {1'b1, 4'h0};
            7'h06:   decodeSeg = {1'b1, 4'h1};
            7'h5B:   decodeSeg = {1'b1, 4'h2};
            7'h4F:   decodeSeg = {1'b1, 4'h3};
            7'h66:   decodeSeg = {1'b1, 4'h4};
            7'h6D:   decodeSeg = {1'b1, 4'h5};
            7'h7D:   decodeSeg = {1'b1, 4'h6};
            7'h07:   decodeSeg = {1'b1, 4'h7};
            7'h7F:   decodeSeg = {1'b1, 4'h8};
            7'h6F:   decodeSeg = {1'b1, 4'h9};
            7'h77:   decodeSeg = {1'b1, 4'hA};
            7'h7C:   decodeSeg = {1'b1, 4'hB};
            7'h39:   decodeSeg = {1'b1, 4'hC};
            7'h5E:   decodeSeg = {1'b1, 4'hD};
            7'h79:   decodeSeg = {1'b1, 4'hE};
            7'h71:   decodeSeg = {1'b1, 4'hF};
            default: decodeSeg = 5'h00;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            syncA <= '1;
            syncB <= '1;
        end else begin
            syncA <= {an_n, seg_n};
            syncB <= syncA;
        end
    end

    // A change always reloads; otherwise count until the capture edge, then park in HELD.
    always_comb begin
        stateNext   = state;
        cntNext     = cnt;
        heldPatNext = heldPat;
        capture     = 1'b0;
        if (syncB != heldPat) begin
            stateNext   = CHANGING;
            heldPatNext = syncB;
            cntNext     = 8'd1;
        end else if (state != HELD) begin
            cntNext = cnt + 8'd1;
            if (cnt == CAP_CNT) begin
                capture   = 1'b1;
                stateNext = HELD;
            end else begin
                stateNext = COUNTING;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= CHANGING;
            cnt     <= '0;
            heldPat <= '1;
        end else begin
            state   <= stateNext;
            cnt     <= cntNext;
            heldPat <= heldPatNext;
        end
    end

    always_comb begin
        digitIdx = 2'd0;
        anOneHot = 1'b1;
        case (syncB[10:7])
            4'b1110: digitIdx = 2'd0;
            4'b1101: digitIdx = 2'd1;
            4'b1011: digitIdx = 2'd2;
            4'b0111: digitIdx = 2'd3;
            default: anOneHot = 1'b0;
        endcase
    end

    assign {decValid, decNibble} = decodeSeg(~syncB[6:0]);
    assign captureOk  = capture & anOneHot & decValid;
    assign captureErr = capture & anOneHot & ~decValid;

    always_comb begin
        shadowNext = shadow;
        shadowNext[{digitIdx, 2'b00} +: 4] = decNibble;
        seenNext = seen | (4'b0001 << digitIdx);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow      <= '0;
            seen        <= '0;
            frame_data  <= '0;
            frame_valid <= 1'b0;
            digit_err   <= 1'b0;
            err_digit   <= '0;
        end else begin
            frame_valid <= 1'b0;
            digit_err   <= 1'b0;
            if (captureOk) begin
                shadow <= shadowNext;
                if (seenNext == 4'hF) begin
                    frame_data  <= shadowNext;
                    frame_valid <= 1'b1;
                    seen        <= '0;
                end else begin
                    seen <= seenNext;
                end
            end else if (captureErr) begin
                digit_err <= 1'b1;
                err_digit <= digitIdx;
                seen      <= '0;
            end
        end
    end

`ifdef SEVSEG_ERR_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
        end else if (captureErr && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sevseg_scan_decoder.sv
// Randomized and directed bench for sevseg_scan_decoder against a pin-level run-length reference model.
module tb_sevseg_scan_decoder;

    localparam int STABLE = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  segN = 7'h7F;
    logic [3:0]  anN = 4'hF;
    logic [15:0] frame_data;
    logic        frame_valid;
    logic        digit_err;
    logic [1:0]  err_digit;
`ifdef SEVSEG_ERR_CNT_EN
    logic [7:0]  err_count;
`endif

    sevseg_scan_decoder #(.STABLE_CYCLES(STABLE)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_n       (segN),
        .an_n        (anN),
        .frame_data  (frame_data),
        .frame_valid (frame_valid),
        .digit_err   (digit_err),
        .err_digit   (err_digit)
`ifdef SEVSEG_ERR_CNT_EN
        ,
        .err_count   (err_count)
`endif
    );

    always #5 clk = ~clk;

    logic [6:0] segOnTable [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    int compared = 0;
    int mismatched = 0;

    // Observations collected by the stimulus task
    int          cycNum = 0;
    int          fvCount, deCount, bothHigh, fvCycle;
    logic [15:0] lastFrame;
    logic [1:0]  lastErrDigit;

    // Reference model: captures happen when a pin pattern has been sampled STABLE times in a row,
    // and take effect two edges later (synchronizer delay).
    logic [10:0] mPrev;
    int          mRun;
    logic        pend0Valid, pend1Valid;
    logic [10:0] pend0Pat, pend1Pat;
    logic        mSeen [4];
    logic [3:0]  mShadow [4];
    logic [15:0] expFrame;
    logic        expFv, expDe;
    logic [1:0]  expErrDigit;
    logic [7:0]  expErrCount;

    task automatic modelReset();
        mPrev = '1;
        mRun = 0;
        pend0Valid = 1'b0;
        pend1Valid = 1'b0;
        pend0Pat = '1;
        pend1Pat = '1;
        for (int i = 0; i < 4; i++) begin
            mSeen[i] = 1'b0;
            mShadow[i] = 4'h0;
        end
        expFrame = '0;
        expFv = 1'b0;
        expDe = 1'b0;
        expErrDigit = '0;
        expErrCount = '0;
    endtask

    task automatic modelCapture(input logic [10:0] pat);
        logic [3:0] an;
        logic [6:0] segOn;
        int zeros, idx, nib;
        logic all;
        an = pat[10:7];
        segOn = ~pat[6:0];
        zeros = 0;
        idx = 0;
        nib = -1;
        for (int b = 0; b < 4; b++) begin
            if (!an[b]) begin
                zeros++;
                idx = b;
            end
        end
        if (zeros != 1) return;
        for (int n = 0; n < 16; n++) if (segOn == segOnTable[n]) nib = n;
        if (nib < 0) begin
            expDe = 1'b1;
            expErrDigit = 2'(idx);
            for (int i = 0; i < 4; i++) mSeen[i] = 1'b0;
            if (expErrCount != 8'd255) expErrCount = expErrCount + 8'd1;
        end else begin
            mShadow[idx] = 4'(nib);
            mSeen[idx] = 1'b1;
            all = mSeen[0] & mSeen[1] & mSeen[2] & mSeen[3];
            if (all) begin
                expFrame = {mShadow[3], mShadow[2], mShadow[1], mShadow[0]};
                expFv = 1'b1;
                for (int i = 0; i < 4; i++) mSeen[i] = 1'b0;
            end
        end
    endtask

    task automatic modelEdge();
        logic [10:0] cur;
        expFv = 1'b0;
        expDe = 1'b0;
        if (pend1Valid) modelCapture(pend1Pat);
        pend1Valid = pend0Valid;
        pend1Pat = pend0Pat;
        cur = {anN, segN};
        if (cur == mPrev) begin
            if (mRun <= STABLE) mRun++;
        end else begin
            mRun = 1;
        end
        mPrev = cur;
        pend0Valid = (mRun == STABLE);
        pend0Pat = cur;
    endtask

    task automatic cycle(input logic [6:0] seg, input logic [3:0] an);
        segN = seg;
        anN = an;
        @(posedge clk);
        cycNum++;
        modelEdge();
        #1;
        if (frame_valid) begin
            fvCount++;
            lastFrame = frame_data;
            fvCycle = cycNum;
        end
        if (digit_err) begin
            deCount++;
            lastErrDigit = err_digit;
        end
        if (frame_valid && digit_err) bothHigh++;
    endtask

    task automatic clearObs();
        fvCount = 0;
        deCount = 0;
        bothHigh = 0;
        fvCycle = -1;
        lastFrame = '0;
        lastErrDigit = '0;
    endtask

    task automatic showDigit(input int idx, input int nib, input int hold, input int gap);
        logic [3:0] an;
        an = ~(4'b0001 << idx);
        repeat (hold) cycle(~segOnTable[nib], an);
        repeat (gap) cycle(7'h7F, 4'hF);
    endtask

    task automatic doReset();
        segN = 7'h7F;
        anN = 4'hF;
        rst_n = 1'b0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        doReset();
        compared++;
        if (frame_data !== 16'h0000) begin mismatched++; $display("FAIL reset_frame_data: got %h want 0000", frame_data); end
        compared++;
        if (frame_valid !== 1'b0 || digit_err !== 1'b0) begin
            mismatched++; $display("FAIL reset_pulses: got fv=%b de=%b want 0 0", frame_valid, digit_err);
        end
        compared++;
        if (err_digit !== 2'd0) begin mismatched++; $display("FAIL reset_err_digit: got %0d want 0", err_digit); end
`ifdef SEVSEG_ERR_CNT_EN
        compared++;
        if (err_count !== 8'd0) begin mismatched++; $display("FAIL reset_err_count: got %0d want 0", err_count); end
`endif
        clearObs();
        showDigit(3, 1, 8, 2);
        showDigit(2, 2, 8, 2);
        showDigit(1, 3, 8, 2);
        showDigit(0, 4, 8, 2);
        repeat (4) cycle(7'h7F, 4'hF);
        compared++;
        if (frame_data !== 16'h1234) begin mismatched++; $display("FAIL pre_async_frame: got %h want 1234", frame_data); end
        // Asynchronous: outputs must clear before any clock edge
        rst_n = 1'b0;
        modelReset();
        #2;
        compared++;
        if (frame_data !== 16'h0000) begin mismatched++; $display("FAIL async_reset_frame: got %h want 0000", frame_data); end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_scan();
        int c0;
        doReset();
        clearObs();
        showDigit(3, 1, 8, 2);
        showDigit(2, 2, 8, 2);
        showDigit(1, 10, 8, 2);
        c0 = cycNum + 1;
        showDigit(0, 15, 8, 2);
        repeat (4) cycle(7'h7F, 4'hF);
        compared++;
        if (fvCount !== 1) begin mismatched++; $display("FAIL scan_fv_count: got %0d want 1", fvCount); end
        compared++;
        if (lastFrame !== 16'h12AF) begin mismatched++; $display("FAIL scan_frame: got %h want 12af", lastFrame); end
        compared++;
        if (deCount !== 0) begin mismatched++; $display("FAIL scan_de_count: got %0d want 0", deCount); end
        compared++;
        if (fvCycle !== c0 + STABLE + 1) begin
            mismatched++; $display("FAIL scan_latency: got cycle %0d want %0d", fvCycle, c0 + STABLE + 1);
        end
    endtask

    task automatic test_blank_error();
        doReset();
        clearObs();
        showDigit(3, 1, 8, 2);
        showDigit(1, 3, 8, 2);
        showDigit(0, 4, 8, 2);
        repeat (8) cycle(7'h7F, 4'b1011);
        repeat (4) cycle(7'h7F, 4'hF);
        compared++;
        if (deCount !== 1) begin mismatched++; $display("FAIL blank_de_count: got %0d want 1", deCount); end
        compared++;
        if (lastErrDigit !== 2'd2) begin mismatched++; $display("FAIL blank_err_digit: got %0d want 2", lastErrDigit); end
        compared++;
        if (fvCount !== 0) begin mismatched++; $display("FAIL blank_fv_count: got %0d want 0", fvCount); end
        clearObs();
        showDigit(3, 5, 8, 2);
        showDigit(2, 6, 8, 2);
        showDigit(1, 7, 8, 2);
        showDigit(0, 8, 8, 2);
        repeat (4) cycle(7'h7F, 4'hF);
        compared++;
        if (fvCount !== 1 || lastFrame !== 16'h5678) begin
            mismatched++; $display("FAIL blank_recover: got %0d frames last %h want 1 frame 5678", fvCount, lastFrame);
        end
    endtask

    task automatic test_flicker();
        doReset();
        clearObs();
        showDigit(3, 1, 8, 2);
        showDigit(2, 2, 8, 2);
        showDigit(1, 3, 8, 2);
        for (int t = 0; t < 8; t++) begin
            repeat (3) cycle(~segOnTable[(t % 2 == 0) ? 0 : 8], 4'b1110);
        end
        compared++;
        if (fvCount !== 0 || deCount !== 0) begin
            mismatched++; $display("FAIL flicker_no_capture: got fv=%0d de=%0d want 0 0", fvCount, deCount);
        end
        showDigit(0, 12, 8, 2);
        repeat (4) cycle(7'h7F, 4'hF);
        compared++;
        if (fvCount !== 1 || lastFrame !== 16'h123C) begin
            mismatched++; $display("FAIL flicker_settle: got %0d frames last %h want 1 frame 123c", fvCount, lastFrame);
        end
    endtask

    task automatic test_multi_low();
        doReset();
        clearObs();
        showDigit(3, 10, 8, 2);
        showDigit(2, 11, 8, 2);
        repeat (20) cycle(~segOnTable[5], 4'b0011);
        repeat (2) cycle(7'h7F, 4'hF);
        compared++;
        if (fvCount !== 0 || deCount !== 0) begin
            mismatched++; $display("FAIL multi_low_ignored: got fv=%0d de=%0d want 0 0", fvCount, deCount);
        end
        showDigit(1, 12, 8, 2);
        showDigit(0, 13, 8, 2);
        repeat (4) cycle(7'h7F, 4'hF);
        compared++;
        if (fvCount !== 1 || lastFrame !== 16'hABCD) begin
            mismatched++; $display("FAIL multi_low_frame: got %0d frames last %h want 1 frame abcd", fvCount, lastFrame);
        end
    endtask

    task automatic test_reset_mid();
        doReset();
        clearObs();
        showDigit(2, 1, 8, 2);
        showDigit(1, 2, 8, 2);
        showDigit(0, 3, 8, 2);
        doReset();
        showDigit(3, 9, 8, 2);
        showDigit(2, 8, 8, 2);
        showDigit(1, 7, 8, 2);
        showDigit(0, 6, 8, 2);
        repeat (4) cycle(7'h7F, 4'hF);
        compared++;
        if (fvCount !== 1) begin mismatched++; $display("FAIL reset_mid_fv_count: got %0d want 1", fvCount); end
        compared++;
        if (lastFrame !== 16'h9876) begin mismatched++; $display("FAIL reset_mid_frame: got %h want 9876", lastFrame); end
    endtask

    task automatic test_err_saturation();
        doReset();
        clearObs();
        repeat (300) begin
            repeat (5) cycle(7'h7F, 4'b1110);
            cycle(7'h7F, 4'hF);
        end
        repeat (6) cycle(7'h7F, 4'hF);
        compared++;
        if (deCount !== 300) begin mismatched++; $display("FAIL sat_de_count: got %0d want 300", deCount); end
        compared++;
        if (bothHigh !== 0 || fvCount !== 0) begin
            mismatched++; $display("FAIL sat_pulses: got both=%0d fv=%0d want 0 0", bothHigh, fvCount);
        end
`ifdef SEVSEG_ERR_CNT_EN
        compared++;
        if (err_count !== 8'd255) begin mismatched++; $display("FAIL sat_err_count: got %0d want 255", err_count); end
        doReset();
        compared++;
        if (err_count !== 8'd0) begin mismatched++; $display("FAIL sat_err_count_reset: got %0d want 0", err_count); end
`endif
    endtask

    task automatic test_random();
        logic [3:0] an;
        logic [6:0] seg;
        int hold, sel;
        doReset();
        clearObs();
        for (int k = 0; k < 400; k++) begin
            sel = int'($urandom_range(0, 99));
            if (sel < 70)      an = ~(4'b0001 << $urandom_range(0, 3));
            else if (sel < 85) an = 4'hF;
            else               an = 4'($urandom);
            if ($urandom_range(0, 99) < 80) seg = ~segOnTable[$urandom_range(0, 15)];
            else                            seg = 7'($urandom);
            hold = int'($urandom_range(1, 8));
            for (int h = 0; h < hold; h++) begin
                cycle(seg, an);
                compared++;
                if (frame_valid !== expFv) begin
                    mismatched++; $display("FAIL rand_frame_valid cyc %0d: got %b want %b", cycNum, frame_valid, expFv);
                end
                compared++;
                if (digit_err !== expDe) begin
                    mismatched++; $display("FAIL rand_digit_err cyc %0d: got %b want %b", cycNum, digit_err, expDe);
                end
                compared++;
                if (frame_data !== expFrame) begin
                    mismatched++; $display("FAIL rand_frame_data cyc %0d: got %h want %h", cycNum, frame_data, expFrame);
                end
                compared++;
                if (err_digit !== expErrDigit) begin
                    mismatched++; $display("FAIL rand_err_digit cyc %0d: got %0d want %0d", cycNum, err_digit, expErrDigit);
                end
`ifdef SEVSEG_ERR_CNT_EN
                compared++;
                if (err_count !== expErrCount) begin
                    mismatched++; $display("FAIL rand_err_count cyc %0d: got %0d want %0d", cycNum, err_count, expErrCount);
                end
`endif
            end
        end
        compared++;
        if (bothHigh !== 0) begin mismatched++; $display("FAIL rand_both_high: got %0d want 0", bothHigh); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        modelReset();
        clearObs();
        test_reset();
        test_scan();
        test_blank_error();
        test_flicker();
        test_multi_low();
        test_reset_mid();
        test_err_saturation();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
